// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate among IFN managers.
// Produces the request-path grant/select and a response-path select that
// follows each accepted transfer through a DLY-deep pipeline. A manager can
// lock the bus for back-to-back transfers by asserting man_lck.
module tcb_lib_arbiter #(
  parameter  int IFN = 4,
  parameter  int DLY = 1,
  localparam int IDW = $clog2(IFN)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [IFN-1:0] man_vld,
  input  logic [IFN-1:0] man_lck,
  input  logic           sub_rdy,
  output logic [IFN-1:0] man_rdy,
  output logic           sub_vld,
  output logic [IDW-1:0] req_sel,
  output logic           rsp_vld,
  output logic [IDW-1:0] rsp_sel
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           lck_act_q, lck_act_d;
  logic [IDW-1:0] lck_idx_q, lck_idx_d;
  logic [IDW-1:0] sel_q, sel_d;

  logic [IDW-1:0] gnt_idx;
  logic           gnt_vld;
  logic           xfer;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Grant: locked owner wins outright; otherwise scan from ptr with wrap at IFN.
  always_comb begin
    gnt_idx = sel_q;
    gnt_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    if (lck_act_q) begin
      gnt_idx = lck_idx_q;
      gnt_vld = man_vld[lck_idx_q];
    end else begin
      for (int k = 0; k < IFN; k++) begin
        // ptr < IFN and k < IFN, so one subtraction is enough to wrap
        sum = {1'b0, ptr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(IFN)) sum = sum - (IDW+1)'(IFN);
        cand = sum[IDW-1:0];
        if (!gnt_vld && man_vld[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held, even with requests pending.
  assign req_sel = rst ? gnt_idx : '0;
  assign sub_vld = rst & gnt_vld;
  assign xfer    = sub_vld & sub_rdy;

  // Only the granted manager sees ready, and only when the handshake completes.
  always_comb begin
    man_rdy = '0;
    if (xfer) man_rdy[req_sel] = 1'b1;
  end

  // Next state: pointer advance and lock capture/release happen on a transfer.
  always_comb begin
    ptr_d     = ptr_q;
    lck_act_d = lck_act_q;
    lck_idx_d = lck_idx_q;
    sel_d     = sub_vld ? req_sel : sel_q;
    if (xfer) begin
      ptr_d     = (req_sel == IDW'(IFN-1)) ? '0 : req_sel + 1'b1;
      lck_act_d = man_lck[req_sel];
      if (man_lck[req_sel]) lck_idx_d = req_sel;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      lck_act_q <= 1'b0;
      lck_idx_q <= '0;
      sel_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lck_act_q <= lck_act_d;
      lck_idx_q <= lck_idx_d;
      sel_q     <= sel_d;
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign rsp_vld = xfer;
      assign rsp_sel = req_sel;
    end else begin : g_dly
      logic [DLY-1:0]          vld_pipe_q, vld_pipe_d;
      logic [DLY-1:0][IDW-1:0] idx_pipe_q, idx_pipe_d;

      // Fixed-delay shift of {transfer, owner}; no response backpressure.
      always_comb begin
        vld_pipe_d[0] = xfer;
        idx_pipe_d[0] = req_sel;
        for (int k = 1; k < DLY; k++) begin
          vld_pipe_d[k] = vld_pipe_q[k-1];
          idx_pipe_d[k] = idx_pipe_q[k-1];
        end
      end

      // Response pipeline register; reset discards in-flight responses.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_pipe_q <= '0;
          idx_pipe_q <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          idx_pipe_q <= idx_pipe_d;
        end
      end

      assign rsp_vld = vld_pipe_q[DLY-1];
      assign rsp_sel = idx_pipe_q[DLY-1];
    end
  endgenerate

endmodule
